// File: rtl/video_dma_fetch.sv
// video_dma_fetch
//
// Purpose:
//   Fetches one display line of bytes from system RAM over a req/ack
//   handshake into a ping-pong line buffer. The pixel side reads the bank
//   that is not being filled. Supports a configurable line width, frame
//   height, line-repeat mode and a sticky underrun flag.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   frame_start  in   pulse: load base_addr, clear line/repeat/byte counters,
//                     abort any fetch
//   line_start   in   pulse: begin the next display line
//   base_addr    in   frame start address (AW bits)
//   mem_req      out  RAM read request
//   mem_addr     out  RAM read address (AW bits)
//   mem_ack      in   RAM data valid, completes the request
//   mem_rdata    in   RAM read data (8 bits)
//   pix_idx      in   byte index within the displaying bank (6 bits)
//   pix_byte     out  displayed byte, one cycle after pix_idx
//   busy         out  fetch in progress
//   frame_done   out  pulse after the fetch of the last line slot
//   underrun     out  sticky, line_start arrived while busy
//   underrun_cnt out  saturating underrun event count
//
// Build option:
//   VDMA_UNDERRUN_CNT_EN - when defined, underrun_cnt counts underrun events
//   (saturating at 255). When undefined, underrun_cnt is tied to 0.

module video_dma_fetch #(
    parameter int AW             = 12,
    parameter int BYTES_PER_LINE = 8,
    parameter int LINES          = 128,
    parameter int LINE_REPEAT    = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_start,
    input  logic          line_start,
    input  logic [AW-1:0] base_addr,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [7:0]    mem_rdata,
    input  logic [5:0]    pix_idx,
    output logic [7:0]    pix_byte,
    output logic          busy,
    output logic          frame_done,
    output logic          underrun,
    output logic [7:0]    underrun_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SWAP  = 2'd2
    } state_t;

    localparam logic [5:0] LAST_BYTE  = 6'(BYTES_PER_LINE - 1);
    localparam logic [6:0] LINE_BYTES = 7'(BYTES_PER_LINE);
    localparam logic [7:0] LAST_LINE  = 8'(LINES - 1);
    localparam logic [2:0] LAST_REP   = 3'(LINE_REPEAT - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   cur_addr_q, cur_addr_d;
    logic [5:0]      byte_cnt_q, byte_cnt_d;
    logic [7:0]      line_cnt_q, line_cnt_d;
    logic [2:0]      rep_cnt_q, rep_cnt_d;
    logic            fill_bank_q, fill_bank_d;
    logic            frame_over_q, frame_over_d;
    logic            frame_done_q, frame_done_d;
    logic            underrun_q;
    logic            underrun_evt;
    logic            buf_we;
    logic            line_go;
    logic [7:0]      pix_byte_q;
    logic [7:0]      pix_rd;

    // Both banks live in one array; the top index bit selects the bank.
    logic [7:0]      line_buf_q [0:127];

    // Next-state logic. frame_start is applied first so that a line_start in
    // the same cycle begins the first line of the new frame.
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        byte_cnt_d   = byte_cnt_q;
        line_cnt_d   = line_cnt_q;
        rep_cnt_d    = rep_cnt_q;
        fill_bank_d  = fill_bank_q;
        frame_over_d = frame_over_q;
        frame_done_d = 1'b0;
        underrun_evt = 1'b0;
        buf_we       = 1'b0;
        line_go      = 1'b0;

        if (frame_start) begin
            state_d      = IDLE;
            cur_addr_d   = base_addr;
            byte_cnt_d   = '0;
            line_cnt_d   = '0;
            rep_cnt_d    = '0;
            frame_over_d = 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (mem_ack) begin
                        buf_we     = 1'b1;
                        cur_addr_d = cur_addr_q + AW'(1);
                        if (byte_cnt_q == LAST_BYTE) begin
                            byte_cnt_d = '0;
                            state_d    = SWAP;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 6'd1;
                        end
                    end
                end
                SWAP: begin
                    fill_bank_d = ~fill_bank_q;
                    state_d     = IDLE;
                    // The last slot ends the frame; the counter holds there.
                    if (line_cnt_q == LAST_LINE) begin
                        frame_done_d = 1'b1;
                        frame_over_d = 1'b1;
                    end else begin
                        line_cnt_d = line_cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase

            // A line_start during a fetch is dropped, only flagged.
            if (line_start && (state_q != IDLE)) begin
                underrun_evt = 1'b1;
            end
        end

        // Accept a line when idle (or just aborted by frame_start) and the
        // frame still has slots. Only the first pass of a repeat group fetches.
        line_go = line_start && (frame_start || (state_q == IDLE)) && !frame_over_d;
        if (line_go) begin
            if (rep_cnt_d == 3'd0) begin
                state_d = FETCH;
            end
            rep_cnt_d = (rep_cnt_d == LAST_REP) ? 3'd0 : rep_cnt_d + 3'd1;
        end
    end

    // Indices past the line width read as zero.
    always_comb begin
        pix_rd = 8'h00;
        if ({1'b0, pix_idx} < LINE_BYTES) begin
            pix_rd = line_buf_q[{~fill_bank_q, pix_idx}];
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cur_addr_q   <= '0;
            byte_cnt_q   <= '0;
            line_cnt_q   <= '0;
            rep_cnt_q    <= '0;
            fill_bank_q  <= 1'b0;
            frame_over_q <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            pix_byte_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            byte_cnt_q   <= byte_cnt_d;
            line_cnt_q   <= line_cnt_d;
            rep_cnt_q    <= rep_cnt_d;
            fill_bank_q  <= fill_bank_d;
            frame_over_q <= frame_over_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_q | underrun_evt;
            pix_byte_q   <= pix_rd;
        end
    end

    // Line buffer storage has no reset; an ack during reset is discarded.
    always_ff @(posedge clk) begin
        if (buf_we && !reset) begin
            line_buf_q[{fill_bank_q, byte_cnt_q}] <= mem_rdata;
        end
    end

`ifdef VDMA_UNDERRUN_CNT_EN
    logic [7:0] underrun_cnt_q;

    // Saturating event counter, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_cnt_q <= 8'd0;
        end else if (underrun_evt && (underrun_cnt_q != 8'hFF)) begin
            underrun_cnt_q <= underrun_cnt_q + 8'd1;
        end
    end

    assign underrun_cnt = underrun_cnt_q;
`else
    assign underrun_cnt = 8'd0;
`endif

    // The request drops in the same cycle reset is asserted.
    assign mem_req    = (state_q == FETCH) && !reset;
    assign mem_addr   = cur_addr_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;
    assign pix_byte   = pix_byte_q;

endmodule

// File: tb/tb_video_dma_fetch.sv
// tb_video_dma_fetch
//
// Purpose:
//   Directed self-checking bench for video_dma_fetch. Instance dutA uses the
//   default geometry (8 bytes/line, 128 lines, no repeat); instance dutB uses
//   LINES=2 and LINE_REPEAT=4. Each has a RAM model returning
//   addr[7:0] ^ 8'hA5 with a programmable ack delay.
//
// Build option:
//   VDMA_UNDERRUN_CNT_EN selects the expected underrun_cnt value.

module tb_video_dma_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Instance A signals
    logic        frameStartA, lineStartA;
    logic [11:0] baseAddrA;
    logic        memReqA, memAckA;
    logic [11:0] memAddrA;
    logic [7:0]  memRdataA;
    logic [5:0]  pixIdxA;
    logic [7:0]  pixByteA;
    logic        busyA, frameDoneA, underrunA;
    logic [7:0]  underrunCntA;

    // Instance B signals
    logic        frameStartB, lineStartB;
    logic [11:0] baseAddrB;
    logic        memReqB, memAckB;
    logic [11:0] memAddrB;
    logic [7:0]  memRdataB;
    logic [5:0]  pixIdxB;
    logic [7:0]  pixByteB;
    logic        busyB, frameDoneB, underrunB;
    logic [7:0]  underrunCntB;

    // RAM models and monitors
    int          ackDelayA = 0;
    int          ackDelayB = 0;
    int          waitA = 0;
    int          waitB = 0;
    logic [11:0] logA[$];
    logic [11:0] logB[$];
    int          stabErrA = 0;
    logic        holdValidA = 1'b0;
    logic [11:0] holdAddrA = '0;
    int          doneCntB = 0;

    int total = 0;
    int bad = 0;

    function automatic logic [7:0] memByte(input logic [11:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    assign memAckA   = memReqA && (waitA == ackDelayA);
    assign memAckB   = memReqB && (waitB == ackDelayB);
    assign memRdataA = memByte(memAddrA);
    assign memRdataB = memByte(memAddrB);

    video_dma_fetch #(.AW(12), .BYTES_PER_LINE(8), .LINES(128), .LINE_REPEAT(1)) dutA (
        .clk(clk), .reset(reset), .frame_start(frameStartA), .line_start(lineStartA),
        .base_addr(baseAddrA), .mem_req(memReqA), .mem_addr(memAddrA), .mem_ack(memAckA),
        .mem_rdata(memRdataA), .pix_idx(pixIdxA), .pix_byte(pixByteA), .busy(busyA),
        .frame_done(frameDoneA), .underrun(underrunA), .underrun_cnt(underrunCntA)
    );

    video_dma_fetch #(.AW(12), .BYTES_PER_LINE(8), .LINES(2), .LINE_REPEAT(4)) dutB (
        .clk(clk), .reset(reset), .frame_start(frameStartB), .line_start(lineStartB),
        .base_addr(baseAddrB), .mem_req(memReqB), .mem_addr(memAddrB), .mem_ack(memAckB),
        .mem_rdata(memRdataB), .pix_idx(pixIdxB), .pix_byte(pixByteB), .busy(busyB),
        .frame_done(frameDoneB), .underrun(underrunB), .underrun_cnt(underrunCntB)
    );

    // RAM model A: ack delay counter, completed-request log, address stability
    always @(posedge clk) begin
        if (memReqA && !memAckA) waitA <= waitA + 1;
        else waitA <= 0;
        if (memReqA && memAckA) logA.push_back(memAddrA);
        if (holdValidA && memReqA && (memAddrA !== holdAddrA)) stabErrA <= stabErrA + 1;
        holdValidA <= memReqA && !memAckA;
        holdAddrA  <= memAddrA;
    end

    // RAM model B: ack delay counter, request log, frame_done pulse count
    always @(posedge clk) begin
        if (memReqB && !memAckB) waitB <= waitB + 1;
        else waitB <= 0;
        if (memReqB && memAckB) logB.push_back(memAddrB);
        if (frameDoneB === 1'b1) doneCntB <= doneCntB + 1;
    end

    // Watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic pulseA(input logic fs, input logic ls, input logic [11:0] base);
        baseAddrA = base; frameStartA = fs; lineStartA = ls;
        @(negedge clk);
        frameStartA = 1'b0; lineStartA = 1'b0;
    endtask

    task automatic pulseB(input logic fs, input logic ls, input logic [11:0] base);
        baseAddrB = base; frameStartB = fs; lineStartB = ls;
        @(negedge clk);
        frameStartB = 1'b0; lineStartB = 1'b0;
    endtask

    task automatic waitIdleA(output int cycles);
        cycles = 0;
        while (busyA === 1'b1 && cycles < 1000) begin cycles++; @(negedge clk); end
    endtask

    task automatic waitIdleB(output int cycles);
        cycles = 0;
        while (busyB === 1'b1 && cycles < 1000) begin cycles++; @(negedge clk); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (memReqA !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_req: got %b want 0", memReqA); end
        total++; if (memAddrA !== 12'h000) begin bad++; $display("[TB] FAIL reset_mem_addr: got %h want 000", memAddrA); end
        total++; if (busyA !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busyA); end
        total++; if (frameDoneA !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame_done: got %b want 0", frameDoneA); end
        total++; if (underrunA !== 1'b0) begin bad++; $display("[TB] FAIL reset_underrun: got %b want 0", underrunA); end
        total++; if (pixByteA !== 8'h00) begin bad++; $display("[TB] FAIL reset_pix_byte: got %h want 00", pixByteA); end
        total++; if (underrunCntA !== 8'h00) begin bad++; $display("[TB] FAIL reset_underrun_cnt: got %h want 00", underrunCntA); end
        total++; if (busyB !== 1'b0 || memReqB !== 1'b0 || underrunCntB !== 8'h00) begin
            bad++; $display("[TB] FAIL reset_dutB: busy=%b req=%b cnt=%h want 0 0 00", busyB, memReqB, underrunCntB);
        end
        reset = 1'b0;
        @(negedge clk);
        total++; if (busyA !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_busy: got %b want 0", busyA); end
    endtask

    task automatic test_basic_fetch();
        int cyc, b;
        $display("[TB] basic fetch from 0x900");
        ackDelayA = 0;
        pulseA(1'b1, 1'b0, 12'h900);
        b = logA.size();
        pulseA(1'b0, 1'b1, 12'h900);
        waitIdleA(cyc);
        total++; if (cyc !== 9) begin bad++; $display("[TB] FAIL basic_busy_cycles: got %0d want 9", cyc); end
        total++; if (logA.size() - b !== 8) begin bad++; $display("[TB] FAIL basic_req_count: got %0d want 8", logA.size() - b); end
        for (int i = 0; i < 8; i++) begin
            total++; if (logA[b + i] !== 12'h900 + 12'(i)) begin
                bad++; $display("[TB] FAIL basic_addr[%0d]: got %h want %h", i, logA[b + i], 12'h900 + 12'(i));
            end
        end
        pixIdxA = 6'd3; @(negedge clk);
        total++; if (pixByteA !== 8'hA6) begin bad++; $display("[TB] FAIL basic_pix3: got %h want a6", pixByteA); end
        pixIdxA = 6'd7; @(negedge clk);
        total++; if (pixByteA !== 8'hA2) begin bad++; $display("[TB] FAIL basic_pix7: got %h want a2", pixByteA); end
        pixIdxA = 6'd8; @(negedge clk);
        total++; if (pixByteA !== 8'h00) begin bad++; $display("[TB] FAIL basic_pix8: got %h want 00", pixByteA); end
        total++; if (frameDoneA !== 1'b0) begin bad++; $display("[TB] FAIL basic_frame_done: got %b want 0", frameDoneA); end
    endtask

    task automatic test_stretched_handshake();
        int cyc, b, s0;
        $display("[TB] stretched handshake, ack after 3 waits");
        ackDelayA = 3;
        b = logA.size();
        s0 = stabErrA;
        pulseA(1'b0, 1'b1, 12'h000);
        waitIdleA(cyc);
        total++; if (cyc !== 33) begin bad++; $display("[TB] FAIL stretch_busy_cycles: got %0d want 33", cyc); end
        total++; if (logA.size() - b !== 8) begin bad++; $display("[TB] FAIL stretch_req_count: got %0d want 8", logA.size() - b); end
        total++; if (logA[b] !== 12'h908) begin bad++; $display("[TB] FAIL stretch_first_addr: got %h want 908", logA[b]); end
        total++; if (logA[b + 7] !== 12'h90F) begin bad++; $display("[TB] FAIL stretch_last_addr: got %h want 90f", logA[b + 7]); end
        total++; if (stabErrA !== s0) begin bad++; $display("[TB] FAIL stretch_addr_stable: got %0d changes want 0", stabErrA - s0); end
        pixIdxA = 6'd0; @(negedge clk);
        total++; if (pixByteA !== 8'hAD) begin bad++; $display("[TB] FAIL stretch_pix0: got %h want ad", pixByteA); end
        pixIdxA = 6'd5; @(negedge clk);
        total++; if (pixByteA !== 8'hA8) begin bad++; $display("[TB] FAIL stretch_pix5: got %h want a8", pixByteA); end
    endtask

    task automatic test_wrap();
        int cyc, b;
        logic [11:0] expAddr [8] = '{12'hFFC, 12'hFFD, 12'hFFE, 12'hFFF, 12'h000, 12'h001, 12'h002, 12'h003};
        $display("[TB] address wrap with coincident frame_start and line_start");
        ackDelayA = 0;
        b = logA.size();
        pulseA(1'b1, 1'b1, 12'hFFC);
        waitIdleA(cyc);
        total++; if (cyc !== 9) begin bad++; $display("[TB] FAIL wrap_busy_cycles: got %0d want 9", cyc); end
        for (int i = 0; i < 8; i++) begin
            total++; if (logA[b + i] !== expAddr[i]) begin
                bad++; $display("[TB] FAIL wrap_addr[%0d]: got %h want %h", i, logA[b + i], expAddr[i]);
            end
        end
        pixIdxA = 6'd4; @(negedge clk);
        total++; if (pixByteA !== 8'hA5) begin bad++; $display("[TB] FAIL wrap_pix4: got %h want a5", pixByteA); end
        pixIdxA = 6'd3; @(negedge clk);
        total++; if (pixByteA !== 8'h5A) begin bad++; $display("[TB] FAIL wrap_pix3: got %h want 5a", pixByteA); end
    endtask

    task automatic test_underrun();
        int cyc, b;
        logic [7:0] expCnt;
`ifdef VDMA_UNDERRUN_CNT_EN
        expCnt = 8'd1;
`else
        expCnt = 8'd0;
`endif
        $display("[TB] underrun: second line_start during a slow fetch");
        ackDelayA = 20;
        pulseA(1'b1, 1'b0, 12'h900);
        b = logA.size();
        pulseA(1'b0, 1'b1, 12'h900);
        repeat (4) @(negedge clk);
        total++; if (underrunA !== 1'b0) begin bad++; $display("[TB] FAIL underrun_early: got %b want 0", underrunA); end
        pulseA(1'b0, 1'b1, 12'h900);
        total++; if (underrunA !== 1'b1) begin bad++; $display("[TB] FAIL underrun_flag: got %b want 1", underrunA); end
        waitIdleA(cyc);
        total++; if (busyA !== 1'b0) begin bad++; $display("[TB] FAIL underrun_fetch_done: busy got %b want 0", busyA); end
        total++; if (logA.size() - b !== 8) begin bad++; $display("[TB] FAIL underrun_req_count: got %0d want 8", logA.size() - b); end
        total++; if (logA[b + 7] !== 12'h907) begin bad++; $display("[TB] FAIL underrun_last_addr: got %h want 907", logA[b + 7]); end
        repeat (30) @(negedge clk);
        total++; if (busyA !== 1'b0 || logA.size() - b !== 8) begin
            bad++; $display("[TB] FAIL underrun_no_requeue: busy=%b reqs=%0d want 0 8", busyA, logA.size() - b);
        end
        total++; if (underrunA !== 1'b1) begin bad++; $display("[TB] FAIL underrun_sticky: got %b want 1", underrunA); end
        total++; if (underrunCntA !== expCnt) begin bad++; $display("[TB] FAIL underrun_cnt: got %h want %h", underrunCntA, expCnt); end
    endtask

    task automatic test_abort_reset();
        int n, b;
        $display("[TB] reset during byte 4");
        ackDelayA = 2;
        pulseA(1'b1, 1'b0, 12'h900);
        total++; if (underrunA !== 1'b1) begin bad++; $display("[TB] FAIL frame_start_keeps_underrun: got %b want 1", underrunA); end
        b = logA.size();
        pulseA(1'b0, 1'b1, 12'h900);
        n = 0;
        while (logA.size() < b + 4 && n < 200) begin n++; @(negedge clk); end
        total++; if (logA.size() - b !== 4) begin bad++; $display("[TB] FAIL abort_wait_byte4: got %0d reqs want 4", logA.size() - b); end
        total++; if (memReqA !== 1'b1 || memAddrA !== 12'h904) begin
            bad++; $display("[TB] FAIL abort_pre_state: req=%b addr=%h want 1 904", memReqA, memAddrA);
        end
        reset = 1'b1;
        @(negedge clk);
        total++; if (memReqA !== 1'b0) begin bad++; $display("[TB] FAIL abort_mem_req: got %b want 0", memReqA); end
        total++; if (busyA !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy: got %b want 0", busyA); end
        total++; if (memAddrA !== 12'h000) begin bad++; $display("[TB] FAIL abort_mem_addr: got %h want 000", memAddrA); end
        total++; if (underrunA !== 1'b0 || underrunCntA !== 8'h00) begin
            bad++; $display("[TB] FAIL abort_underrun: flag=%b cnt=%h want 0 00", underrunA, underrunCntA);
        end
        total++; if (pixByteA !== 8'h00 || frameDoneA !== 1'b0) begin
            bad++; $display("[TB] FAIL abort_pix_done: pix=%h done=%b want 00 0", pixByteA, frameDoneA);
        end
        total++; if (logA.size() - b !== 4) begin bad++; $display("[TB] FAIL abort_ack_ignored: got %0d reqs want 4", logA.size() - b); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abort_frame();
        int n, b, cyc;
        $display("[TB] frame_start mid-fetch restarts at new base");
        ackDelayA = 2;
        pulseA(1'b1, 1'b0, 12'h900);
        b = logA.size();
        pulseA(1'b0, 1'b1, 12'h900);
        n = 0;
        while (logA.size() < b + 3 && n < 200) begin n++; @(negedge clk); end
        pulseA(1'b1, 1'b0, 12'hA40);
        total++; if (memReqA !== 1'b0 || busyA !== 1'b0) begin
            bad++; $display("[TB] FAIL fabort_stop: req=%b busy=%b want 0 0", memReqA, busyA);
        end
        total++; if (memAddrA !== 12'hA40) begin bad++; $display("[TB] FAIL fabort_addr: got %h want a40", memAddrA); end
        total++; if (logA.size() - b !== 3) begin bad++; $display("[TB] FAIL fabort_partial: got %0d reqs want 3", logA.size() - b); end
        pixIdxA = 6'd5; @(negedge clk);
        total++; if (pixByteA !== 8'hA0) begin bad++; $display("[TB] FAIL fabort_no_swap: got %h want a0", pixByteA); end
        pulseA(1'b0, 1'b1, 12'hA40);
        waitIdleA(cyc);
        total++; if (logA.size() - b !== 11) begin bad++; $display("[TB] FAIL fabort_refetch_count: got %0d want 11", logA.size() - b); end
        total++; if (logA[b + 3] !== 12'hA40 || logA[b + 10] !== 12'hA47) begin
            bad++; $display("[TB] FAIL fabort_refetch_addr: first=%h last=%h want a40 a47", logA[b + 3], logA[b + 10]);
        end
        pixIdxA = 6'd0; @(negedge clk);
        total++; if (pixByteA !== 8'hE5) begin bad++; $display("[TB] FAIL fabort_pix0: got %h want e5", pixByteA); end
        pixIdxA = 6'd7; @(negedge clk);
        total++; if (pixByteA !== 8'hE2) begin bad++; $display("[TB] FAIL fabort_pix7: got %h want e2", pixByteA); end
    endtask

    task automatic test_repeat_frame_end();
        int cyc, b, d0;
        logic [7:0] expPix [8] = '{8'hA7, 8'hA7, 8'hA7, 8'hA7, 8'hAF, 8'hAF, 8'hAF, 8'hAF};
        int expLog [8] = '{8, 8, 8, 8, 16, 16, 16, 16};
        int expBusy [8] = '{9, 0, 0, 0, 9, 0, 0, 0};
        int expDone [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
        $display("[TB] line repeat 4, frame of 2 slots");
        ackDelayB = 0;
        pulseB(1'b1, 1'b0, 12'h900);
        b = logB.size();
        d0 = doneCntB;
        for (int i = 0; i < 8; i++) begin
            pulseB(1'b0, 1'b1, 12'h900);
            waitIdleB(cyc);
            total++; if (cyc !== expBusy[i]) begin bad++; $display("[TB] FAIL rep_busy[%0d]: got %0d want %0d", i, cyc, expBusy[i]); end
            pixIdxB = 6'd2; @(negedge clk);
            total++; if (pixByteB !== expPix[i]) begin bad++; $display("[TB] FAIL rep_pix[%0d]: got %h want %h", i, pixByteB, expPix[i]); end
            total++; if (logB.size() - b !== expLog[i]) begin
                bad++; $display("[TB] FAIL rep_reqs[%0d]: got %0d want %0d", i, logB.size() - b, expLog[i]);
            end
            total++; if (doneCntB - d0 !== expDone[i]) begin
                bad++; $display("[TB] FAIL rep_frame_done[%0d]: got %0d want %0d", i, doneCntB - d0, expDone[i]);
            end
        end
        total++; if (logB[b] !== 12'h900 || logB[b + 8] !== 12'h908 || logB[b + 15] !== 12'h90F) begin
            bad++; $display("[TB] FAIL rep_addrs: got %h %h %h want 900 908 90f", logB[b], logB[b + 8], logB[b + 15]);
        end
        pulseB(1'b0, 1'b1, 12'h900);
        total++; if (busyB !== 1'b0) begin bad++; $display("[TB] FAIL frame_end_ignore_busy: got %b want 0", busyB); end
        repeat (3) @(negedge clk);
        total++; if (logB.size() - b !== 16 || doneCntB - d0 !== 1) begin
            bad++; $display("[TB] FAIL frame_end_ignore: reqs=%0d done=%0d want 16 1", logB.size() - b, doneCntB - d0);
        end
        total++; if (underrunB !== 1'b0) begin bad++; $display("[TB] FAIL frame_end_underrun: got %b want 0", underrunB); end
    endtask

    initial begin
        reset = 1'b1;
        frameStartA = 1'b0; lineStartA = 1'b0; baseAddrA = '0; pixIdxA = '0;
        frameStartB = 1'b0; lineStartB = 1'b0; baseAddrB = '0; pixIdxB = '0;
        test_reset();
        test_basic_fetch();
        test_stretched_handshake();
        test_wrap();
        test_underrun();
        test_abort_reset();
        test_abort_frame();
        test_repeat_frame_end();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_dma_fetch.md
Name: video_dma_fetch

Overview:
- Parametrised successor to the fixed CDP1861-style display fetch path.
- Fetches one display line of bytes from system RAM over a req/ack handshake into a ping-pong line buffer.
- The pixel side reads the buffer bank that is not being filled.
- Adds configurable line width, frame height, a line-repeat mode and underrun detection, none of which the fixed-function path has.

Parameters:
AW, 12, RAM address width; addresses wrap modulo 2^AW
BYTES_PER_LINE, 8, bytes fetched per displayed line (1..64)
LINES, 128, fetched-line slots per frame (1..256)
LINE_REPEAT, 1, display passes per fetched line (1..8); address advances only after the last pass

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse; latches base_addr, clears line/repeat counters
line_start  in  1  one-cycle pulse; begins the next display line
base_addr  in  AW  frame start address, sampled on frame_start
mem_req  out  1  RAM read request
mem_addr  out  AW  RAM read address
mem_ack  in  1  RAM data valid this cycle; completes the request
mem_rdata  in  8  RAM read data
pix_idx  in  6  byte index within the displaying bank
pix_byte  out  8  displayed byte, 1-cycle registered latency
busy  out  1  fetch in progress
frame_done  out  1  one-cycle pulse after the fetch for slot LINES-1 completes
underrun  out  1  sticky; set when a line_start arrives while busy
underrun_cnt  out  8  see Optional Feature

Behaviour:
- Reset values: mem_req=0, mem_addr=0, busy=0, frame_done=0, underrun=0, pix_byte=0, underrun_cnt=0. Fill bank=0, display bank=1, all counters 0, state IDLE.
- Reset mid-fetch: returns to IDLE the next cycle. mem_req drops immediately. A pending ack is ignored.
- States:
  - IDLE: waits for line_start.
  - FETCH: mem_req=1 with mem_addr=cur_addr. On mem_ack, write mem_rdata to fill_bank[byte_cnt], increment cur_addr (wraps at 2^AW) and byte_cnt.
  - After the byte at BYTES_PER_LINE-1 is acked: go to SWAP.
  - SWAP: one cycle. Exchange banks, go to IDLE.
- Handshake rules:
  - mem_req stays high with a stable mem_addr until ack. Back-to-back acks are legal, so peak rate is 1 byte/cycle.
  - mem_ack while mem_req=0 is ignored.
- Line repeat:
  - On line_start, if rep_cnt != 0, no fetch occurs and banks are not swapped; rep_cnt increments (wraps to 0 at LINE_REPEAT).
  - cur_addr advances only on fetches.
  - With LINE_REPEAT=1, every line_start fetches.
- Line counter: line_cnt increments at each SWAP. At LINES-1 it pulses frame_done and holds; further line_starts in that frame are ignored until the next frame_start.
- frame_start:
  - Loads cur_addr=base_addr and clears line_cnt, rep_cnt and byte_cnt.
  - Aborts any fetch: mem_req=0, state IDLE, no swap.
  - Does not clear underrun.
- frame_start and line_start in the same cycle: frame_start is applied first, then the line begins immediately as the first line of the new frame.
- Underrun:
  - A line_start while busy sets underrun (sticky until reset).
  - The current fetch completes normally. The extra line_start is dropped, not queued.
- Pixel read: pix_byte <= disp_bank[pix_idx] every cycle. pix_idx >= BYTES_PER_LINE reads 0.
- busy = (state != IDLE).

Optional Feature:
- Macro VDMA_UNDERRUN_CNT_EN.
- Defined: underrun_cnt increments on each underrun event, saturates at 255, and clears only on reset.
- Undefined: underrun_cnt is tied to 0 and no counter logic is built; the sticky underrun flag behaves identically in both cases.

Test Plan:
- Basic fetch: base_addr=0x900, frame_start, line_start, memory model acks every cycle -> 8 requests at 0x900..0x907, then banks swap; pix_idx=3 returns byte at 0x903 one cycle later.
- Stretched handshake: ack delayed 3 cycles per request -> mem_addr stable while mem_req=1, no duplicate writes, busy high for 8×4+1 cycles.
- Repeat: LINE_REPEAT=4, 8 line_starts -> fetches only at lines 0 and 4 (0x900 then 0x908); display data unchanged across repeats.
- Wrap and frame end:
  - AW=12, base_addr=0xFFC, line_start -> addresses 0xFFC..0xFFF, 0x000..0x003.
  - LINES=2 -> frame_done pulses once after the second line; a third line_start is ignored.
- Underrun: ack delayed 20 cycles, second line_start at cycle 5 -> underrun=1, first fetch completes, no second fetch; with VDMA_UNDERRUN_CNT_EN, underrun_cnt=1.
- Abort: reset asserted during byte 4 -> mem_req=0 the next cycle, all outputs at reset values; frame_start mid-fetch restarts from the new base_addr without a swap.
